// File: rtl/ds_dac_scheduler.sv
// ds_dac_scheduler: sample FIFO plus a playback FSM for ds_DAC.
// Each sample is held on value for HOLD_CYCLES clocks. The bus sits at
// IDLE_VALUE with the modulator cleared while idle, and an empty FIFO at
// a period boundary raises the sticky underrun flag.
module ds_dac_scheduler #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 256,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned IDLE_VALUE  = 128
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          enable,
    input  logic                          s_valid,
    input  logic [WIDTH-1:0]              s_data,
    output logic                          s_ready,
    output logic [WIDTH-1:0]              value,
    output logic                          dac_clrn,
    output logic                          sample_strobe,
    output logic                          underrun,
    input  logic                          clr_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_CODE = WIDTH'(IDLE_VALUE);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push, pop;
    logic             fifo_nonempty;
    logic             at_last;
    logic [WIDTH-1:0] value_d;
    logic             clrn_d;
    logic             strobe_d;
    logic             underrun_set;

    // Full blocks a push even when a pop lands on the same edge.
    assign s_ready       = (fifo_level < LVL_FULL);
    assign push          = s_valid & s_ready;
    assign fifo_nonempty = (fifo_level != '0);
    assign at_last       = (cnt_q == CNT_LAST);

    // FIFO storage write; the array needs no reset because occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Playback state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pop decision and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        cnt_d        = cnt_q;
        value_d      = value;
        clrn_d       = dac_clrn;
        strobe_d     = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                value_d = IDLE_CODE;
                clrn_d  = 1'b0;
                cnt_d   = '0;
                if (enable) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                cnt_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (fifo_nonempty) begin
                    pop      = 1'b1;
                    value_d  = mem[rd_ptr];
                    clrn_d   = 1'b1;
                    strobe_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // enable is only looked at on the terminal count, so the
                // current period always completes.
                if (at_last) begin
                    cnt_d = '0;
                    if (!enable) begin
                        state_d = ST_IDLE;
                        value_d = IDLE_CODE;
                        clrn_d  = 1'b0;
                    end else if (fifo_nonempty) begin
                        pop      = 1'b1;
                        value_d  = mem[rd_ptr];
                        strobe_d = 1'b1;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, hold counter and FIFO pointers/occupancy.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q         <= '0;
            value         <= IDLE_CODE;
            dac_clrn      <= 1'b0;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
        end else begin
            cnt_q         <= cnt_d;
            value         <= value_d;
            dac_clrn      <= clrn_d;
            sample_strobe <= strobe_d;
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_ds_dac_scheduler.sv
// Directed bench for ds_dac_scheduler with HOLD_CYCLES=4, FIFO_DEPTH=4.
// A per-cycle vector table covers playback, underrun and stop; short
// hand-written sequences cover async reset, preload and the full FIFO.
module tb_ds_dac_scheduler;

    logic       clk;
    logic       clr;
    logic       enable;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] value;
    logic       dac_clrn;
    logic       sample_strobe;
    logic       underrun;
    logic       clr_underrun;
    logic [2:0] fifo_level;

    int tests;
    int failed;

    ds_dac_scheduler #(
        .WIDTH       (8),
        .HOLD_CYCLES (4),
        .FIFO_DEPTH  (4),
        .IDLE_VALUE  (128)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .enable        (enable),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .value         (value),
        .dac_clrn      (dac_clrn),
        .sample_strobe (sample_strobe),
        .underrun      (underrun),
        .clr_underrun  (clr_underrun),
        .fifo_level    (fifo_level)
    );

    // Rising edges at 10, 20, 30 ns ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       sv;
        logic [7:0] sd;
        logic       cu;
        logic [7:0] ev;
        logic       ec;
        logic       es;
        logic       eu;
        logic [2:0] el;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input int en, input int sv, input int sd, input int cu,
                        input int ev, input int ec, input int es, input int eu,
                        input int el);
        vec_t v;
        v.en = 1'(en);
        v.sv = 1'(sv);
        v.sd = 8'(sd);
        v.cu = 1'(cu);
        v.ev = 8'(ev);
        v.ec = 1'(ec);
        v.es = 1'(es);
        v.eu = 1'(eu);
        v.el = 3'(el);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ev, input int ec,
                           input int es, input int eu, input int el);
        chk({tag, " value"},      int'(value),         ev);
        chk({tag, " dac_clrn"},   int'(dac_clrn),      ec);
        chk({tag, " strobe"},     int'(sample_strobe), es);
        chk({tag, " underrun"},   int'(underrun),      eu);
        chk({tag, " fifo_level"}, int'(fifo_level),    el);
        chk({tag, " s_ready"},    int'(s_ready),       (el < 4) ? 1 : 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        clr          = 1'b1;
        enable       = 1'b0;
        s_valid      = 1'b0;
        s_data       = 8'd0;
        clr_underrun = 1'b0;

        // Row: inputs before the edge, expected outputs after it.
        //    en sv sd  cu  value clrn strb und lvl
        addv(1, 0,  0, 0,  128, 0, 0, 0, 0);   // IDLE -> PRIME
        addv(1, 1, 10, 0,  128, 0, 0, 0, 1);   // push 10, PRIME saw empty
        addv(1, 1, 20, 0,   10, 1, 1, 0, 1);   // pop 10 + push 20
        addv(1, 1, 30, 0,   10, 1, 0, 0, 2);
        addv(1, 0,  0, 0,   10, 1, 0, 0, 2);
        addv(1, 0,  0, 0,   10, 1, 0, 0, 2);
        addv(1, 0,  0, 0,   20, 1, 1, 0, 1);   // 4 clocks later
        addv(1, 0,  0, 0,   20, 1, 0, 0, 1);
        addv(1, 0,  0, 0,   20, 1, 0, 0, 1);
        addv(1, 0,  0, 0,   20, 1, 0, 0, 1);
        addv(1, 0,  0, 0,   30, 1, 1, 0, 0);
        addv(1, 0,  0, 0,   30, 1, 0, 0, 0);
        addv(1, 0,  0, 0,   30, 1, 0, 0, 0);
        addv(1, 0,  0, 0,   30, 1, 0, 0, 0);
        addv(1, 0,  0, 0,   30, 1, 0, 1, 0);   // empty at boundary
        addv(1, 1, 40, 0,   30, 1, 0, 1, 1);
        addv(1, 0,  0, 0,   30, 1, 0, 1, 1);
        addv(1, 0,  0, 0,   30, 1, 0, 1, 1);
        addv(1, 0,  0, 0,   40, 1, 1, 1, 0);
        addv(1, 0,  0, 1,   40, 1, 0, 0, 0);   // clr_underrun alone
        addv(1, 0,  0, 0,   40, 1, 0, 0, 0);
        addv(1, 0,  0, 0,   40, 1, 0, 0, 0);
        addv(1, 0,  0, 1,   40, 1, 0, 1, 0);   // set beats clear
        addv(1, 0,  0, 0,   40, 1, 0, 1, 0);
        addv(1, 0,  0, 1,   40, 1, 0, 0, 0);
        addv(1, 1, 50, 0,   40, 1, 0, 0, 1);
        addv(1, 1, 60, 0,   50, 1, 1, 0, 1);   // pop + push, level kept
        addv(0, 0,  0, 0,   50, 1, 0, 0, 1);   // enable dropped
        addv(1, 0,  0, 0,   50, 1, 0, 0, 1);   // brief re-enable ignored
        addv(0, 0,  0, 0,   50, 1, 0, 0, 1);
        addv(0, 0,  0, 0,  128, 0, 0, 0, 1);   // period end -> IDLE
        addv(1, 1, 70, 0,  128, 0, 0, 0, 2);
        addv(1, 1, 80, 0,   60, 1, 1, 0, 2);
        addv(1, 1, 90, 0,   60, 1, 0, 0, 3);
        addv(1, 0,  0, 0,   60, 1, 0, 0, 3);

        // Reset state while clr is held.
        #22;
        chk_all("reset", 128, 0, 0, 0, 0);
        #3;
        clr = 1'b0;

        foreach (vecs[i]) begin
            enable       = vecs[i].en;
            s_valid      = vecs[i].sv;
            s_data       = vecs[i].sd;
            clr_underrun = vecs[i].cu;
            tick();
            chk_all($sformatf("row%0d", i), int'(vecs[i].ev), int'(vecs[i].ec),
                    int'(vecs[i].es), int'(vecs[i].eu), int'(vecs[i].el));
        end

        // Async reset between edges while RUN holds 60 with 3 queued.
        #3;
        clr = 1'b1;
        #1;
        chk_all("async_clr", 128, 0, 0, 0, 0);
        #10;
        chk_all("clr_held", 128, 0, 0, 0, 0);
        clr     = 1'b0;
        enable  = 1'b1;
        s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("prime_wait%0d", k), 128, 0, 0, 0, 0);
        end
        s_valid = 1'b1;
        s_data  = 8'd11;
        tick();
        chk_all("prime_push", 128, 0, 0, 0, 1);
        s_valid = 1'b0;
        tick();
        chk_all("prime_pop", 11, 1, 1, 0, 0);

        // Preload while idle until full; 9 waits on the producer side.
        #3;
        clr = 1'b1;
        #2;
        clr    = 1'b0;
        enable = 1'b0;
        chk_all("clr_pulse", 128, 0, 0, 0, 0);
        s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_data = 8'(5 + k);
            tick();
            chk_all($sformatf("preload%0d", k), 128, 0, 0, 0, (k < 4) ? k + 1 : 4);
        end
        tick();
        chk_all("preload_hold", 128, 0, 0, 0, 4);

        // Full FIFO: the pop edge must not also accept the waiting 9.
        enable = 1'b1;
        tick();
        chk_all("full_prime", 128, 0, 0, 0, 4);
        tick();
        chk_all("full_pop", 5, 1, 1, 0, 3);
        tick();
        chk_all("refill", 5, 1, 0, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
